// File: rtl/vga_text_box.sv
// vga_text_box: overlays a ROWS x WIDTH text field onto a pixel stream, with
// per-frame blink and horizontal marquee scroll. Runtime enables are shadowed
// at frame start (x==0, y==0) so a frame is never torn. One cycle latency.
//
// Stream layout (38 bits):
//   [9:0]   x coordinate         [19:10] y coordinate       (pass-through part)
//   [22:20] fg colour            [25:23] bg colour
//   [27:26] zoom                 [28]    ha
//   [36:29] character address    [37]    cs                 (overlay part)
//
// Ports:
//   px_clk     pixel clock
//   reset      synchronous active-high reset
//   in         input pixel stream
//   en         overlay enable, shadowed at frame start
//   blink_en   blink enable, shadowed at frame start
//   scroll_en  marquee enable, shadowed at frame start
//   out        output pixel stream, registered
//   frame_tick registered pulse aligned with the frame-start pixel on out
module vga_text_box #(
   parameter logic [6:0]  LINE       = 7'd0,
   parameter logic [6:0]  COL        = 7'd0,
   parameter int unsigned ROWS       = 1,
   parameter int unsigned WIDTH      = 1,
   parameter logic [1:0]  PZOOM      = 2'b0,
   parameter logic [2:0]  PCOLOR     = 3'b111,
   parameter logic [2:0]  PBGCOLOR   = 3'b000,
   parameter logic [7:0]  OFFSET     = 8'h0,
   parameter logic [7:0]  ROW_STRIDE = 8'd16,
   parameter int unsigned SCROLL_LEN = 16,
   parameter int unsigned SCROLL_DIV = 8,
   parameter int unsigned BLINK_DIV  = 30
) (
   input  logic        px_clk,
   input  logic        reset,
   input  logic [37:0] in,
   input  logic        en,
   input  logic        blink_en,
   input  logic        scroll_en,
   output logic [37:0] out,
   output logic        frame_tick
);

   localparam int unsigned XC_W   = 10;
   localparam int unsigned YC_W   = 10;
   localparam int unsigned P1_W   = XC_W + YC_W;
   localparam int unsigned CELL_W = 7;
   localparam int unsigned CE_W   = CELL_W + 1;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned SCR_W  = (SCROLL_LEN > 1) ? $clog2(SCROLL_LEN) : 1;
   localparam int unsigned SUM_W  = ((SCR_W > CELL_W) ? SCR_W : CELL_W) + 1;
   // Worst-case number of subtractions to bring rel_x+scroll below SCROLL_LEN
   localparam int unsigned NSUB   = (WIDTH + SCROLL_LEN - 2) / SCROLL_LEN;
   localparam logic [CE_W-1:0] COL_END  = CE_W'(32'(COL) + WIDTH);
   localparam logic [CE_W-1:0] LINE_END = CE_W'(32'(LINE) + ROWS);

   logic [XC_W-1:0]   x;
   logic [YC_W-1:0]   y;
   logic              fs;
   logic [CELL_W-1:0] cx, cy, rel_x, rel_y;
   logic              in_field, active;
   logic [SUM_W-1:0]  idx;
   logic [ADDR_W-1:0] addr;
   logic [17:0]       ovl;

   logic              en_s_q, en_s_d;
   logic              blink_s_q, blink_s_d;
   logic              scroll_s_q, scroll_s_d;
   logic [CNT_W-1:0]  bcnt_q, bcnt_d;
   logic              phase_q, phase_d;
   logic [CNT_W-1:0]  scnt_q, scnt_d;
   logic [SCR_W-1:0]  scroll_q, scroll_d;
   logic [37:0]       out_q, out_d;
   logic              tick_q, tick_d;

   assign x  = in[XC_W-1:0];
   assign y  = in[P1_W-1:XC_W];
   assign fs = (x == '0) && (y == '0);
   assign cx = x[XC_W-1:3] >> PZOOM;
   assign cy = y[YC_W-1:3] >> PZOOM;

   // Frame-level state: shadows, blink phase and marquee position.
   // Counters act on the shadows as they were before this frame start.
   always_comb begin
      en_s_d     = en_s_q;
      blink_s_d  = blink_s_q;
      scroll_s_d = scroll_s_q;
      bcnt_d     = bcnt_q;
      phase_d    = phase_q;
      scnt_d     = scnt_q;
      scroll_d   = scroll_q;

      if (fs) begin
         en_s_d     = en;
         blink_s_d  = blink_en;
         scroll_s_d = scroll_en;
      end

      if (!blink_s_q) begin
         bcnt_d  = '0;
         phase_d = 1'b0;
      end else if (fs) begin
         if (bcnt_q == CNT_W'(BLINK_DIV - 1)) begin
            bcnt_d  = '0;
            phase_d = !phase_q;
         end else begin
            bcnt_d = bcnt_q + CNT_W'(1);
         end
      end

      // Disabled marquee freezes in place rather than rewinding
      if (scroll_s_q && fs) begin
         if (scnt_q == CNT_W'(SCROLL_DIV - 1)) begin
            scnt_d   = '0;
            scroll_d = (scroll_q == SCR_W'(SCROLL_LEN - 1)) ? '0 : scroll_q + SCR_W'(1);
         end else begin
            scnt_d = scnt_q + CNT_W'(1);
         end
      end
   end

   // Pixel datapath: field hit test, character address, overlay merge.
   always_comb begin
      in_field = ({1'b0, cx} >= {1'b0, COL})  && ({1'b0, cx} < COL_END) &&
                 ({1'b0, cy} >= {1'b0, LINE}) && ({1'b0, cy} < LINE_END);
      active   = en_s_q && !(blink_s_q && phase_q) && in_field;
      rel_x    = cx - COL;
      rel_y    = cy - LINE;

      // Modulo by compare-subtract; bounded since rel_x < WIDTH, scroll < SCROLL_LEN
      idx = SUM_W'(rel_x) + SUM_W'(scroll_q);
      for (int unsigned k = 0; k < NSUB; k++) begin
         if (idx >= SUM_W'(SCROLL_LEN)) idx = idx - SUM_W'(SCROLL_LEN);
      end

      // Address silently wraps at ADDR_W bits
      addr = OFFSET + ADDR_W'({1'b0, rel_y} * ROW_STRIDE) + ADDR_W'(idx);
      ovl  = {1'b0, addr, 1'b0, PZOOM, PBGCOLOR, PCOLOR};

      out_d = in;
      if (active) out_d[37:P1_W] = in[37:P1_W] | ovl;
      tick_d = fs;
   end

   always_ff @(posedge px_clk) begin
      if (reset) begin
         en_s_q     <= 1'b0;
         blink_s_q  <= 1'b0;
         scroll_s_q <= 1'b0;
         bcnt_q     <= '0;
         phase_q    <= 1'b0;
         scnt_q     <= '0;
         scroll_q   <= '0;
         out_q      <= '0;
         tick_q     <= 1'b0;
      end else begin
         en_s_q     <= en_s_d;
         blink_s_q  <= blink_s_d;
         scroll_s_q <= scroll_s_d;
         bcnt_q     <= bcnt_d;
         phase_q    <= phase_d;
         scnt_q     <= scnt_d;
         scroll_q   <= scroll_d;
         out_q      <= out_d;
         tick_q     <= tick_d;
      end
   end

   assign out        = out_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_vga_text_box.sv
// tb_vga_text_box: drives three differently-parameterised vga_text_box
// instances from one shared stream and compares every output cycle against a
// frame-level arithmetic model, plus directed address/blink/shadow checks.
module tb_vga_text_box;

   logic        clk = 1'b0;
   logic        reset, en, blink_en, scroll_en;
   logic [37:0] in_s, last_in;
   logic [37:0] obs [3];
   logic        tick [3];
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   // Instance parameters mirrored for the model: a = basic, z = zoom, m = marquee/blink
   int p_line [3]  = '{2, 2, 1};
   int p_col  [3]  = '{3, 3, 2};
   int p_rows [3]  = '{2, 2, 3};
   int p_wid  [3]  = '{4, 4, 4};
   int p_zoom [3]  = '{0, 1, 0};
   int p_fg   [3]  = '{7, 2, 7};
   int p_bg   [3]  = '{0, 1, 4};
   int p_off  [3]  = '{32, 64, 0};
   int p_str  [3]  = '{16, 16, 144};
   int p_slen [3]  = '{16, 16, 5};
   int p_sdiv [3]  = '{8, 8, 1};
   int p_bdiv [3]  = '{30, 30, 2};

   // Model frame state
   int m_en [3], m_bs [3], m_ss [3], m_bcnt [3], m_ph [3], m_scnt [3], m_scroll [3];

   vga_text_box #(.LINE(7'd2), .COL(7'd3), .ROWS(2), .WIDTH(4), .PZOOM(2'd0),
      .PCOLOR(3'd7), .PBGCOLOR(3'd0), .OFFSET(8'h20), .ROW_STRIDE(8'd16),
      .SCROLL_LEN(16), .SCROLL_DIV(8), .BLINK_DIV(30)) u_a (
      .px_clk(clk), .reset(reset), .in(in_s), .en(en), .blink_en(blink_en),
      .scroll_en(scroll_en), .out(obs[0]), .frame_tick(tick[0]));

   vga_text_box #(.LINE(7'd2), .COL(7'd3), .ROWS(2), .WIDTH(4), .PZOOM(2'd1),
      .PCOLOR(3'd2), .PBGCOLOR(3'd1), .OFFSET(8'h40), .ROW_STRIDE(8'd16),
      .SCROLL_LEN(16), .SCROLL_DIV(8), .BLINK_DIV(30)) u_z (
      .px_clk(clk), .reset(reset), .in(in_s), .en(en), .blink_en(blink_en),
      .scroll_en(scroll_en), .out(obs[1]), .frame_tick(tick[1]));

   vga_text_box #(.LINE(7'd1), .COL(7'd2), .ROWS(3), .WIDTH(4), .PZOOM(2'd0),
      .PCOLOR(3'd7), .PBGCOLOR(3'd4), .OFFSET(8'h00), .ROW_STRIDE(8'h90),
      .SCROLL_LEN(5), .SCROLL_DIV(1), .BLINK_DIV(2)) u_m (
      .px_clk(clk), .reset(reset), .in(in_s), .en(en), .blink_en(blink_en),
      .scroll_en(scroll_en), .out(obs[2]), .frame_tick(tick[2]));

   task automatic chk(input string tag, input logic [37:0] got, input logic [37:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [37:0] model_out(input int k, input logic [37:0] iv);
      int x, y, cx, cy, idx, addr;
      logic [37:0] r;
      logic [17:0] ov;
      x  = int'(iv[9:0]);
      y  = int'(iv[19:10]);
      cx = x / (8 * (1 << p_zoom[k]));
      cy = y / (8 * (1 << p_zoom[k]));
      r  = iv;
      if (m_en[k] != 0 && !(m_bs[k] != 0 && m_ph[k] != 0) &&
          cx >= p_col[k] && cx < p_col[k] + p_wid[k] &&
          cy >= p_line[k] && cy < p_line[k] + p_rows[k]) begin
         idx  = (cx - p_col[k] + m_scroll[k]) % p_slen[k];
         addr = (p_off[k] + (cy - p_line[k]) * p_str[k] + idx) % 256;
         ov   = {1'b0, 8'(addr), 1'b0, 2'(p_zoom[k]), 3'(p_bg[k]), 3'(p_fg[k])};
         r[37:20] = r[37:20] | ov;
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_en[k] = 0; m_bs[k] = 0; m_ss[k] = 0;
         m_bcnt[k] = 0; m_ph[k] = 0; m_scnt[k] = 0; m_scroll[k] = 0;
      end
   endtask

   // Frame boundary: advance blink/scroll under the old enables, then latch ports
   task automatic model_frame();
      for (int k = 0; k < 3; k++) begin
         if (m_bs[k] != 0) begin
            m_bcnt[k]++;
            if (m_bcnt[k] == p_bdiv[k]) begin m_bcnt[k] = 0; m_ph[k] = 1 - m_ph[k]; end
         end else begin
            m_bcnt[k] = 0; m_ph[k] = 0;
         end
         if (m_ss[k] != 0) begin
            m_scnt[k]++;
            if (m_scnt[k] == p_sdiv[k]) begin
               m_scnt[k] = 0;
               m_scroll[k] = (m_scroll[k] + 1) % p_slen[k];
            end
         end
         m_en[k] = int'(en); m_bs[k] = int'(blink_en); m_ss[k] = int'(scroll_en);
      end
   endtask

   task automatic step(input int x, input int y, input logic [17:0] p2);
      logic [37:0] ex [3];
      logic        fs;
      in_s = {p2, 10'(y), 10'(x)};
      fs   = (x == 0) && (y == 0);
      for (int k = 0; k < 3; k++) ex[k] = reset ? 38'd0 : model_out(k, in_s);
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("out%0d(%0d,%0d)", k, x, y), obs[k], ex[k]);
         chk($sformatf("tick%0d(%0d,%0d)", k, x, y), 38'(tick[k]), 38'(!reset && fs));
      end
      last_in = in_s;
      if (reset) model_reset();
      else if (fs) model_frame();
   endtask

   task automatic rand_pixels(input int n);
      int x, y;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            x = int'($urandom_range(0, 79));
            y = int'($urandom_range(0, 71));
         end else begin
            x = int'($urandom_range(0, 1023));
            y = int'($urandom_range(0, 1023));
         end
         if (x == 0 && y == 0) x = 1;
         step(x, y, 18'($urandom));
      end
   endtask

   initial begin
      logic drawn;
      logic found;
      reset = 1'b1; en = 1'b0; blink_en = 1'b0; scroll_en = 1'b0;
      in_s = '0; last_in = '0;
      model_reset();

      // Reset state
      step(5, 5, 18'($urandom));
      step(0, 0, 18'($urandom));
      chk("reset_out_a", obs[0], 38'd0);
      chk("reset_tick_m", 38'(tick[2]), 38'd0);
      reset = 1'b0;

      // Frame 0: en raised mid-frame, no overlay yet
      step(0, 0, 18'($urandom));
      rand_pixels(20);
      en = 1'b1;
      step(24, 16, 18'd0);
      chk("shadow_en_pass_a", obs[0], last_in);
      rand_pixels(20);

      // Frame 1: basic overlay and zoom addresses
      step(0, 0, 18'($urandom));
      chk("fs_tick_a", 38'(tick[0]), 38'd1);
      step(24, 16, 18'd0); chk("a_addr_24_16", 38'(obs[0][36:29]), 38'h20);
      step(55, 16, 18'd0); chk("a_addr_55_16", 38'(obs[0][36:29]), 38'h23);
      step(24, 24, 18'd0); chk("a_addr_24_24", 38'(obs[0][36:29]), 38'h30);
      step(56, 16, 18'd0); chk("a_pass_56_16", obs[0], last_in);
      step(48, 32, 18'd0); chk("z_addr_48_32", 38'(obs[1][36:29]), 38'h40);
      step(47, 32, 18'd0); chk("z_pass_47_32", obs[1], last_in);
      rand_pixels(60);

      // Marquee on u_m: scroll 0,1,2,3,4,0 over successive frames
      scroll_en = 1'b1;
      for (int f = 0; f < 6; f++) begin
         step(0, 0, 18'($urandom));
         step(16, 8, 18'd0);
         chk($sformatf("m_idx0_f%0d", f), 38'(obs[2][36:29]), 38'(f % 5));
         if (f == 3) begin
            step(24, 8, 18'd0); chk("m_idx1_s3", 38'(obs[2][36:29]), 38'd4);
            step(32, 8, 18'd0); chk("m_idx2_s3", 38'(obs[2][36:29]), 38'd0);
            step(40, 8, 18'd0); chk("m_idx3_s3", 38'(obs[2][36:29]), 38'd1);
         end
         rand_pixels(30);
      end

      // Blink on u_m: drawn 1,2 hidden 3,4 drawn 5,6; mid-frame disable in 4
      scroll_en = 1'b0;
      blink_en  = 1'b1;
      for (int f = 1; f <= 6; f++) begin
         drawn = (f == 1 || f == 2 || f == 5 || f == 6);
         step(0, 0, 18'($urandom));
         step(16, 8, 18'd0);
         chk($sformatf("m_blink_f%0d", f), 38'(obs[2][22:20]), drawn ? 38'd7 : 38'd0);
         if (f == 4) begin
            blink_en = 1'b0;
            rand_pixels(10);
            step(16, 8, 18'd0);
            chk("m_blink_midframe", 38'(obs[2][22:20]), 38'd0);
         end
         rand_pixels(30);
      end

      // Random frames with mid-frame port changes
      for (int f = 0; f < 4; f++) begin
         step(0, 0, 18'($urandom));
         for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 19) == 0) begin
               en = 1'($urandom); blink_en = 1'($urandom); scroll_en = 1'($urandom);
            end
            rand_pixels(1);
         end
      end

      // Frame-start shadowing: en 0->1 at y=100 takes effect only at next fs
      en = 1'b0; blink_en = 1'b0; scroll_en = 1'b0;
      step(0, 0, 18'($urandom));
      rand_pixels(20);
      en = 1'b1;
      step(5, 100, 18'($urandom));
      step(24, 16, 18'd0);
      chk("shadow_absent_a", obs[0], last_in);
      rand_pixels(10);
      step(0, 0, 18'($urandom));
      chk("shadow_tick_a", 38'(tick[0]), 38'd1);
      chk("shadow_xy0_a", 38'(obs[0][19:0]), 38'd0);
      step(24, 16, 18'd0);
      chk("shadow_present_a", 38'(obs[0][22:20]), 38'd7);

      // Reset mid-operation with u_m at scroll 2
      scroll_en = 1'b1;
      found = 1'b0;
      for (int f = 0; f < 12 && !found; f++) begin
         step(0, 0, 18'($urandom));
         if (m_scroll[2] == 2) found = 1'b1;
         else rand_pixels(5);
      end
      n_cmp++;
      assert (found) else begin
         n_bad++;
         $error("FAIL scroll_reach: observed no frame with scroll 2, expected one within 12 frames");
      end
      step(16, 8, 18'd0);
      chk("m_addr_s2", 38'(obs[2][36:29]), 38'd2);
      reset = 1'b1;
      step(24, 8, 18'($urandom));
      chk("midreset_zero_m", obs[2], 38'd0);
      reset = 1'b0;
      step(24, 8, 18'($urandom));
      chk("midreset_pass_m", obs[2], last_in);
      rand_pixels(20);
      step(0, 0, 18'($urandom));
      step(16, 8, 18'd0);
      chk("postreset_addr_m", 38'(obs[2][36:29]), 38'd0);
      chk("postreset_drawn_m", 38'(obs[2][22:20]), 38'd7);
      rand_pixels(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
